// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative HI/LO multiply/divide unit for the MIPS core.
// Runs a radix-2 shift-add multiply or a restoring divide over WIDTH cycles,
// owns HI/LO, and raises a stall interlock against dependent instructions.
//
// Issue handshake: a request (start_mult/start_div) is taken on the rising
// edge that ends a cycle in which the request is high and stall is low. A
// cycle with a request and stall high takes nothing; the core holds the PC
// and re-presents the same request until stall drops. MFHI/MFLO follow the
// same rule: hilo_out is meaningful only in a cycle where stall is low.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             mfhi_sel,
  input  logic             mflo_sel,
  output logic             stall,
  output logic [WIDTH-1:0] hilo_out,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CW-1:0]      count;
  logic               op_div;     // latched op type: 1 = divide
  logic               neg_res;    // product / quotient needs negation
  logic               neg_rem;    // remainder needs negation (dividend < 0)
  logic               div_zero;   // divisor was zero at issue
  logic [WIDTH-1:0]   opa;        // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc;        // {upper, lower}: product or {rem, quot}

  logic               accept;
  logic [WIDTH-1:0]   rs_mag;
  logic [WIDTH-1:0]   rt_mag;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     mul_upper;
  logic [2*WIDTH-1:0] mul_next;

  logic [WIDTH:0]     div_rem_sh;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] div_next;

  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  assign busy      = (state != IDLE);
  assign stall     = busy & (start_mult | start_div | mfhi_sel | mflo_sel);
  assign accept    = (state == IDLE) & (start_mult | start_div);
  assign hilo_out  = mfhi_sel ? hi : lo;
  assign dbg_state = state;

  // Operand magnitudes; raw bits are used for the unsigned forms.
  assign rs_mag = (is_signed & rs_val[WIDTH-1]) ? (~rs_val + 1'b1) : rs_val;
  assign rt_mag = (is_signed & rt_val[WIDTH-1]) ? (~rt_val + 1'b1) : rt_val;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: IDLE -> RUN on accepted issue, WIDTH RUN cycles, one FIX.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (count == CW'(WIDTH - 1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One shift-add step: add multiplicand into the upper half when the
  // multiplier LSB is set, keep the carry, then shift the whole thing right.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opa};
    mul_upper = acc[0] ? mul_sum : {1'b0, acc[2*WIDTH-1:WIDTH]};
    mul_next  = {mul_upper, acc[WIDTH-1:1]};
  end

  // One restoring-divide step: shift {rem,quot} left, trial-subtract the
  // divisor from the widened remainder, keep it and set a quotient bit if
  // the difference is non-negative.
  always_comb begin
    div_rem_sh = acc[2*WIDTH-1:WIDTH-1];
    div_trial  = div_rem_sh - {1'b0, opa};
    if (div_trial[WIDTH]) begin
      div_next = {div_rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      div_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
  end

  // Sign fix-up of the unsigned magnitude result. A zero divisor leaves the
  // quotient at all ones; the remainder then holds |rs|, and the dividend
  // sign fix turns it back into rs exactly as issued.
  always_comb begin
    prod_fixed = neg_res ? (~acc + 1'b1) : acc;
    quot       = acc[WIDTH-1:0];
    rem        = acc[2*WIDTH-1:WIDTH];
    if (op_div) begin
      fix_lo = (neg_res & ~div_zero) ? (~quot + 1'b1) : quot;
      fix_hi = neg_rem ? (~rem + 1'b1) : rem;
    end else begin
      fix_lo = prod_fixed[WIDTH-1:0];
      fix_hi = prod_fixed[2*WIDTH-1:WIDTH];
    end
  end

  // Datapath: latch operands on issue, iterate in RUN, commit HI/LO in FIX.
  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      op_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      opa      <= '0;
      acc      <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= (state == FIX);
      case (state)
        IDLE: begin
          if (accept) begin
            // Mult wins when both starts are raised together.
            op_div   <= ~start_mult;
            neg_res  <= is_signed & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
            neg_rem  <= is_signed & rs_val[WIDTH-1];
            div_zero <= (rt_val == '0);
            count    <= '0;
            if (start_mult) begin
              opa <= rs_mag;
              acc <= {{WIDTH{1'b0}}, rt_mag};
            end else begin
              opa <= rt_mag;
              acc <= {{WIDTH{1'b0}}, rs_mag};
            end
          end
        end
        RUN: begin
          acc   <= op_div ? div_next : mul_next;
          count <= count + 1'b1;
        end
        FIX: begin
          hi <= fix_hi;
          lo <= fix_lo;
        end
        default: begin
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Testbench for muldiv_sequencer: directed interlock/latency scenarios plus
// randomized MULT/MULTU/DIV/DIVU traffic against a plain-arithmetic model.
module tb_muldiv_sequencer;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         start_mult;
  logic         start_div;
  logic         is_signed;
  logic [W-1:0] rs_val;
  logic [W-1:0] rt_val;
  logic         mfhi_sel;
  logic         mflo_sel;
  logic         stall;
  logic [W-1:0] hilo_out;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         done;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;

  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] mon_exp;
  logic [W-1:0]   ref_hi;
  logic [W-1:0]   ref_lo;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_mult (start_mult),
    .start_div  (start_div),
    .is_signed  (is_signed),
    .rs_val     (rs_val),
    .rt_val     (rt_val),
    .mfhi_sel   (mfhi_sel),
    .mflo_sel   (mflo_sel),
    .stall      (stall),
    .hilo_out   (hilo_out),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: {HI, LO} from MIPS arithmetic rules.
  function automatic logic [2*W-1:0] model(input bit is_div, input bit sgn,
                                           input logic [W-1:0] a, input logic [W-1:0] b);
    longint         sa, sb, q, m;
    logic [2*W-1:0] ua, ub, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {{W{1'b0}}, a};
    ub = {{W{1'b0}}, b};
    if (!is_div) begin
      if (sgn) r = 64'(sa * sb);
      else     r = ua * ub;
    end else if (b == '0) begin
      r = {a, {W{1'b1}}};
    end else if (sgn) begin
      q = sa / sb;
      m = sa % sb;
      r = {m[W-1:0], q[W-1:0]};
    end else begin
      r = {W'(ua % ub), W'(ua / ub)};
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return W'($urandom_range(0, 15));
      default: return W'($urandom);
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 expected=0");
      end else begin
        mon_exp = exp_q.pop_front();
        check("result_hi", hi, mon_exp[2*W-1:W]);
        check("result_lo", lo, mon_exp[W-1:0]);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start_mult = 1'b0;
    start_div  = 1'b0;
    is_signed  = 1'b0;
    rs_val     = '0;
    rt_val     = '0;
    mfhi_sel   = 1'b0;
    mflo_sel   = 1'b0;
  endtask

  // Issue in the current (idle or done) cycle; also reads old HI/LO in C0.
  task automatic issue(input bit do_mult, input bit do_div, input bit sgn,
                       input logic [W-1:0] a, input logic [W-1:0] b, input bit peek_hi);
    logic [2*W-1:0] res;
    start_mult = do_mult;
    start_div  = do_div;
    is_signed  = sgn;
    rs_val     = a;
    rt_val     = b;
    mfhi_sel   = peek_hi;
    mflo_sel   = ~peek_hi;
    #1;
    check("issue_stall", stall, 1'b0);
    check("c0_old_hilo", hilo_out, peek_hi ? ref_hi : ref_lo);
    res = model(!do_mult, sgn, a, b);
    exp_q.push_back(res);
    ref_hi = res[2*W-1:W];
    ref_lo = res[W-1:0];
    next_cycle();
    clear_inputs();
  endtask

  // Count cycles until done; lat is the cycle index relative to issue C0.
  task automatic wait_done(input int expected_lat, input int start_lat);
    int lat;
    bit seen;
    lat  = start_lat;
    seen = 1'b0;
    while (lat < expected_lat + 20) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      next_cycle();
      lat++;
    end
    if (seen) begin
      check("latency", W'(lat), W'(expected_lat));
    end else begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=none expected=cycle_%0d", expected_lat);
    end
    #1;
  endtask

  task automatic op_expect(input bit do_mult, input bit do_div, input bit sgn,
                           input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] e_hi, input logic [W-1:0] e_lo,
                           input string name);
    issue(do_mult, do_div, sgn, a, b, 1'b0);
    wait_done(W + 2, 1);
    check({name, "_hi"}, hi, e_hi);
    check({name, "_lo"}, lo, e_lo);
  endtask

  initial begin
    clear_inputs();
    reset  = 1'b1;
    ref_hi = '0;
    ref_lo = '0;
    repeat (3) next_cycle();
    reset    = 1'b0;
    mflo_sel = 1'b1;
    #1;
    check("rst_hi", hi, '0);
    check("rst_lo", lo, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_stall", stall, 1'b0);
    mflo_sel = 1'b0;
    next_cycle();

    // Signed 7 * -3 with MFLO held from C1: stalls through C33, reads in C34.
    issue(1'b1, 1'b0, 1'b1, 32'd7, 32'hFFFF_FFFD, 1'b1);
    mflo_sel = 1'b1;
    for (int k = 1; k <= W + 1; k++) begin
      #1;
      check("mflo_stall", stall, 1'b1);
      next_cycle();
    end
    #1;
    check("mflo_release", stall, 1'b0);
    check("mflo_done", done, 1'b1);
    check("mflo_value", hilo_out, 32'hFFFF_FFEB);
    check("mflo_hi", hi, 32'hFFFF_FFFF);
    mflo_sel = 1'b0;

    // Test-plan corners, issued back-to-back in each done cycle.
    op_expect(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
    op_expect(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7_2");
    op_expect(1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_ovf");
    op_expect(1'b0, 1'b1, 1'b0, 32'h0000_0064, 32'h0, 32'h0000_0064, 32'hFFFF_FFFF, "divu_zero");
    op_expect(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_neg_zero");
    op_expect(1'b1, 1'b1, 1'b0, 32'd6, 32'd5, 32'h0, 32'd30, "both_starts");

    // Independent instruction in C5, second MULT presented from C10.
    issue(1'b1, 1'b0, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    repeat (4) next_cycle();
    #1;
    check("add_c5_stall", stall, 1'b0);
    repeat (5) next_cycle();
    start_mult = 1'b1;
    is_signed  = 1'b1;
    rs_val     = 32'hFFFF_F000;
    rt_val     = 32'h0000_0123;
    for (int k = 10; k <= W + 1; k++) begin
      #1;
      check("mult2_stall", stall, 1'b1);
      next_cycle();
    end
    #1;
    check("mult2_accept_stall", stall, 1'b0);
    check("mult2_accept_done", done, 1'b1);
    mon_exp = model(1'b0, 1'b1, 32'hFFFF_F000, 32'h0000_0123);
    exp_q.push_back(mon_exp);
    ref_hi = mon_exp[2*W-1:W];
    ref_lo = mon_exp[W-1:0];
    next_cycle();
    clear_inputs();
    wait_done(2 * (W + 2), W + 3);

    // Reset in C10 of a multiply: result discarded, HI/LO cleared.
    issue(1'b1, 1'b0, 1'b0, 32'd1000, 32'd1000, 1'b0);
    repeat (9) next_cycle();
    reset = 1'b1;
    exp_q.delete();
    ref_hi = '0;
    ref_lo = '0;
    next_cycle();
    reset    = 1'b0;
    mflo_sel = 1'b1;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_hi", hi, '0);
    check("mid_rst_lo", lo, '0);
    check("mid_rst_stall", stall, 1'b0);
    check("mid_rst_done", done, 1'b0);
    mflo_sel = 1'b0;
    repeat (W + 8) next_cycle();

    // Randomized traffic, back-to-back.
    for (int i = 0; i < 40; i++) begin
      bit m, s, p;
      logic [W-1:0] a, b;
      m = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      p = 1'($urandom_range(0, 1));
      a = rand_operand();
      b = rand_operand();
      issue(m, ~m, s, a, b, p);
      wait_done(W + 2, 1);
    end

    repeat (3) next_cycle();
    check("queue_drained", W'(exp_q.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
